// File: rtl/sync_ram_bank.sv
// rtl/sync_ram_bank.sv - simple dual-port RAM bank with byte enables, registered read and power-on clear
//
// Purpose:
//   One write port with per-byte enables and one read port with a 1-cycle
//   registered read. After reset a clear sequencer zeroes every word, one
//   word per clock. The bank ignores traffic until that sequence completes.
//
// Optional feature macro: SYNC_RAM_BANK_PARITY_EN
//   Defined   : one even-parity bit is stored per byte and checked on reads.
//   Undefined : no parity storage is built and rd_perr is tied low.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ready     out  clear sequence done, requests accepted
//   wr_en     in   write request
//   wr_addr   in   write address
//   wr_data   in   write data
//   wr_be     in   byte enables, bit i covers wr_data[8i+7:8i]
//   rd_en     in   read request
//   rd_addr   in   read address
//   rd_data   out  registered read data, held while rd_valid=0
//   rd_valid  out  one-cycle strobe for new rd_data
//   rd_perr   out  parity error on the current read
module sync_ram_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_perr
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    same_addr;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    perr_next;

  assign wr_fire   = (state == READY) && wr_en;
  assign rd_fire   = (state == READY) && rd_en;
  assign same_addr = wr_fire && (wr_addr == rd_addr);

  // Storage is deliberately not reset; the CLEAR state owns the zeroing.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Write-first merge: bytes being written this edge bypass the array.
  always_comb begin
    rd_word = mem[rd_addr];
    for (int i = 0; i < NBYTES; i++) begin
      if (same_addr && wr_be[i]) begin
        rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

`ifdef SYNC_RAM_BANK_PARITY_EN
  logic [NBYTES-1:0] par [DEPTH];

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      par[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) begin
          par[wr_addr][i] <= ^wr_data[8*i +: 8];
        end
      end
    end
  end

  // Forwarded bytes carry freshly computed parity, so only stored bytes are checked.
  always_comb begin
    perr_next = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (!(same_addr && wr_be[i])) begin
        if ((^mem[rd_addr][8*i +: 8]) != par[rd_addr][i]) begin
          perr_next = 1'b1;
        end
      end
    end
  end
`else
  assign perr_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ready    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_perr  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_perr  <= rd_fire && perr_next;
      if (rd_fire) begin
        rd_data <= rd_word;
      end
      if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
        // The edge that clears the last word also opens the bank.
        if (&clr_addr) begin
          state <= READY;
          ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_ram_bank.sv
// tb/tb_sync_ram_bank.sv - self-checking bench for sync_ram_bank
module tb_sync_ram_bank;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NB    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ready;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NB-1:0] wr_be = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_perr;

  int tests = 0;
  int fails = 0;

  // Scoreboard entries: {expected rd_perr, expected rd_data}
  logic [DW:0] exp_q[$];
  bit          issued = 1'b0;
  logic [DW-1:0] last_data = '0;

  typedef struct {
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NB-1:0] be;
    bit            re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sync_ram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_perr  (rd_perr)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
  endtask

  task automatic do_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic perr);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back({perr, exp});
    issued  = 1'b1;
  endtask

  // Advance one edge, sample 1 time unit later, score the read port.
  task automatic tick();
    logic [DW:0] e;
    @(posedge clk);
    #1;
    check("rd_valid", {31'b0, rd_valid}, {31'b0, issued});
    if (issued) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_data, e[DW-1:0]);
        check("rd_perr", {31'b0, rd_perr}, {31'b0, e[DW]});
        last_data = e[DW-1:0];
      end
    end else begin
      check("rd_perr_idle", {31'b0, rd_perr}, 32'd0);
    end
    issued = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    wr_be  = '0;
  endtask

  // Clear sequence with traffic attempted every edge; ready only after edge DEPTH.
  task automatic clear_phase();
    for (int i = 1; i <= DEPTH; i++) begin
      do_wr(AW'(i), 32'hFFFF_FFFF, 4'hF);
      rd_en   = 1'b1;
      rd_addr = AW'(i);
      tick();
      check($sformatf("ready_edge%0d", i), {31'b0, ready}, {31'b0, (i == DEPTH)});
    end
  endtask

  initial begin
    // Table: reads of every address after clear, then write/read patterns.
    for (int a = 0; a < DEPTH; a++) vecs.push_back('{0, 0, 0, 0, 1, AW'(a), 32'h0});
    vecs.push_back('{1, 4'd3, 32'hDEAD_BEEF, 4'hF,    0, 4'd0, 32'h0});
    vecs.push_back('{1, 4'd3, 32'h1122_3344, 4'b0101, 0, 4'd0, 32'h0});
    vecs.push_back('{0, 4'd0, 32'h0,         4'h0,    1, 4'd3, 32'hDE22_BE44});
    vecs.push_back('{1, 4'd7, 32'h0102_0304, 4'hF,    0, 4'd0, 32'h0});
    vecs.push_back('{1, 4'd7, 32'hCAFE_F00D, 4'b1100, 1, 4'd7, 32'hCAFE_0304});
    vecs.push_back('{0, 4'd0, 32'h0,         4'h0,    1, 4'd7, 32'hCAFE_0304});
    vecs.push_back('{1, 4'd3, 32'hFFFF_FFFF, 4'h0,    1, 4'd3, 32'hDE22_BE44});
    vecs.push_back('{1, 4'd9, 32'hA5A5_A5A5, 4'hF,    1, 4'd3, 32'hDE22_BE44});
    vecs.push_back('{0, 4'd0, 32'h0,         4'h0,    1, 4'd9, 32'hA5A5_A5A5});
    vecs.push_back('{0, 4'd0, 32'h0,         4'h0,    1, 4'd7, 32'hCAFE_0304});
    vecs.push_back('{0, 4'd0, 32'h0,         4'h0,    0, 4'd0, 32'h0});
    vecs.push_back('{1, 4'd0, 32'h1234_5678, 4'b1000, 0, 4'd0, 32'h0});
    vecs.push_back('{1, 4'd15, 32'h8765_4321, 4'hF,   1, 4'd0, 32'h1200_0000});
    vecs.push_back('{0, 4'd0, 32'h0,         4'h0,    1, 4'd15, 32'h8765_4321});
    vecs.push_back('{0, 4'd0, 32'h0,         4'h0,    0, 4'd0, 32'h0});

    // Reset values, asserted asynchronously between edges.
    #2 rst_n = 1'b0;
    #1;
    check("reset_ready",    {31'b0, ready},    32'd0);
    check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("reset_rd_data",  rd_data,           32'd0);
    check("reset_rd_perr",  {31'b0, rd_perr},  32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    clear_phase();

    foreach (vecs[k]) begin
      if (vecs[k].we) do_wr(vecs[k].wa, vecs[k].wd, vecs[k].be);
      if (vecs[k].re) do_rd(vecs[k].ra, vecs[k].exp, 1'b0);
      tick();
      if (!vecs[k].re) check($sformatf("hold_v%0d", k), rd_data, last_data);
    end

    // Reset in the middle of traffic while rd_valid is high.
    do_rd(4'd9, 32'hA5A5_A5A5, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready",    {31'b0, ready},    32'd0);
    check("midrst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("midrst_rd_data",  rd_data,           32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_phase();
    do_rd(4'd9, 32'h0, 1'b0);
    tick();
    do_rd(4'd3, 32'h0, 1'b0);
    tick();
    do_rd(4'd7, 32'h0, 1'b0);
    tick();

`ifdef SYNC_RAM_BANK_PARITY_EN
    do_wr(4'd5, 32'h0F0F_0F0F, 4'hF);
    tick();
    dut.mem[5] = dut.mem[5] ^ 32'h0000_0001;
    do_rd(4'd5, 32'h0F0F_0F0E, 1'b1);
    tick();
    do_rd(4'd4, 32'h0, 1'b0);
    tick();
    do_rd(4'd9, 32'h0, 1'b0);
    tick();
`endif

    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
